// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer
//   Standard I2S transmitter running on the audio reference clock. BCLK and
//   LRCK are integer divisions of refclk. Stereo PCM pairs arrive through a
//   single-entry valid/ready holding register. Each channel is sent MSB-first
//   with a one-BCLK delay after the LRCK edge. A frame that starts with the
//   holding register empty is sent as silence and flagged as an underrun.
//
// Ports
//   refclk      in   audio clock, rising edge
//   rst         in   synchronous active-high reset
//   in_valid    in   sample pair presented
//   in_ready    out  holding register empty
//   in_left     in   left sample, two's complement, DATA_W bits
//   in_right    in   right sample, two's complement, DATA_W bits
//   bclk        out  bit clock (registered)
//   lrck        out  word select, 0 = left, 1 = right (registered)
//   sdata       out  serial data (registered)
//   frame_start out  one-cycle pulse on the tick that begins a frame
//   underrun    out  one-cycle pulse when a frame starts with no sample held
module i2s_tx_serializer #(
  parameter int DATA_W   = 24,
  parameter int SLOT_W   = 32,
  parameter int MCLK_DIV = 4
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_left,
  input  logic [DATA_W-1:0] in_right,
  output logic              bclk,
  output logic              lrck,
  output logic              sdata,
  output logic              frame_start,
  output logic              underrun
);

  localparam int FRAME = 2 * SLOT_W;
  localparam int C_W   = $clog2(MCLK_DIV);
  localparam int B_W   = $clog2(FRAME);

  localparam logic [C_W-1:0] CNT_MAX  = C_W'(MCLK_DIV - 1);
  localparam logic [C_W-1:0] CNT_HALF = C_W'(MCLK_DIV / 2);
  localparam logic [B_W-1:0] B_MAX    = B_W'(FRAME - 1);
  localparam logic [B_W-1:0] B_SLOT   = B_W'(SLOT_W);
  localparam logic [B_W-1:0] B_DATA   = B_W'(DATA_W);

  logic [C_W-1:0]    r_cnt;
  logic [B_W-1:0]    r_b;
  logic              r_full;
  logic [DATA_W-1:0] r_hold_l, r_hold_r;
  logic [DATA_W-1:0] r_word_l, r_word_r;
  logic              r_bclk, r_lrck, r_sdata;

  logic              w_tick, w_fs, w_accept, w_right;
  logic [C_W-1:0]    w_cnt_nxt;
  logic [B_W-1:0]    w_b_nxt, w_lr_b, w_p, w_shamt;
  logic [DATA_W-1:0] w_ld_l, w_ld_r, w_word, w_shifted;
  logic              w_bit;

  assign w_tick    = (r_cnt == CNT_MAX);
  assign w_cnt_nxt = w_tick ? '0 : r_cnt + 1'b1;
  assign w_b_nxt   = (r_b == B_MAX) ? '0 : r_b + 1'b1;
  assign w_fs      = w_tick && (r_b == B_MAX);
  assign w_accept  = in_valid && !r_full;

  // LRCK leads the data by one bit slot, so it is decoded from b+1.
  assign w_lr_b    = (w_b_nxt == B_MAX) ? '0 : w_b_nxt + 1'b1;

  // Channel words for the frame about to start; silence when nothing is held.
  assign w_ld_l    = r_full ? r_hold_l : '0;
  assign w_ld_r    = r_full ? r_hold_r : '0;

  // Slot position and channel of the bit being launched on this tick. On the
  // frame-start tick the words are being loaded, so read the load values.
  assign w_right   = (w_b_nxt >= B_SLOT);
  assign w_p       = w_right ? w_b_nxt - B_SLOT : w_b_nxt;
  assign w_word    = w_fs ? (w_right ? w_ld_r : w_ld_l)
                          : (w_right ? r_word_r : r_word_l);
  assign w_shamt   = B_DATA - 1'b1 - w_p;
  assign w_shifted = w_word >> w_shamt;
  assign w_bit     = (w_p < B_DATA) ? w_shifted[0] : 1'b0;

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_b      <= B_MAX;
      r_full   <= 1'b0;
      r_hold_l <= '0;
      r_hold_r <= '0;
      r_word_l <= '0;
      r_word_r <= '0;
      r_bclk   <= 1'b0;
      r_lrck   <= 1'b0;
      r_sdata  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_bclk <= (w_cnt_nxt >= CNT_HALF);
      if (w_tick) begin
        r_b     <= w_b_nxt;
        r_lrck  <= (w_lr_b >= B_SLOT);
        r_sdata <= w_bit;
      end
      if (w_fs) begin
        r_word_l <= w_ld_l;
        r_word_r <= w_ld_r;
        if (r_full) r_full <= 1'b0;
      end
      // Accept only when empty, so it never collides with the drain above;
      // a sample accepted on an empty frame-start tick waits one frame.
      if (w_accept) begin
        r_full   <= 1'b1;
        r_hold_l <= in_left;
        r_hold_r <= in_right;
      end
    end
  end

  assign in_ready    = !r_full;
  assign bclk        = r_bclk;
  assign lrck        = r_lrck;
  assign sdata       = r_sdata;
  // Suppressed while in reset: the tick is not taken on that edge.
  assign frame_start = w_fs && !rst;
  assign underrun    = w_fs && !r_full && !rst;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
module tb_i2s_tx_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default-parameter DUT
  logic        rst, in_valid, in_ready, bclk, lrck, sdata, frame_start, underrun;
  logic [23:0] in_left, in_right;

  // MCLK_DIV=2, SLOT_W=24, DATA_W=24 DUT
  logic        rst2, v2, rdy2, bclk2, lrck2, sdata2, fs2, un2;
  logic [23:0] l2, r2;

  int checks = 0;
  int errors = 0;

  i2s_tx_serializer dut (
    .refclk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_left(in_left), .in_right(in_right), .bclk(bclk), .lrck(lrck),
    .sdata(sdata), .frame_start(frame_start), .underrun(underrun)
  );

  i2s_tx_serializer #(.DATA_W(24), .SLOT_W(24), .MCLK_DIV(2)) dut2 (
    .refclk(clk), .rst(rst2), .in_valid(v2), .in_ready(rdy2),
    .in_left(l2), .in_right(r2), .bclk(bclk2), .lrck(lrck2),
    .sdata(sdata2), .frame_start(fs2), .underrun(un2)
  );

  // Expected 64-bit I2S frame, index k = bit slot k after the frame start.
  function automatic logic [63:0] exp_frame(input logic [23:0] l, input logic [23:0] r);
    logic [63:0] e;
    e = '0;
    for (int k = 0; k < 64; k++) begin
      if (k < 24)                e[k] = l[23-k];
      else if (k >= 32 && k < 56) e[k] = r[55-k];
    end
    return e;
  endfunction

  function automatic logic [63:0] exp_lr();
    logic [63:0] e;
    for (int k = 0; k < 64; k++) e[k] = (((k + 1) % 64) >= 32);
    return e;
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;  // now in cycle 0 after release
  endtask

  // Waits (bounded) for frame_start, then samples each bit at the bclk-high phase.
  task automatic capture_frame(output logic [63:0] sd, output logic [63:0] lr,
                               output logic [63:0] bc, output logic un, output logic found);
    int w;
    found = 1'b0; un = 1'b0; sd = '0; lr = '0; bc = '0; w = 0;
    while (!found && w < 400) begin
      @(negedge clk); w++;
      if (frame_start) begin found = 1'b1; un = underrun; end
    end
    if (found) begin
      repeat (3) @(negedge clk);
      for (int k = 0; k < 64; k++) begin
        if (k > 0) repeat (4) @(negedge clk);
        sd[k] = sdata; lr[k] = lrck; bc[k] = bclk;
      end
    end
  endtask

  task automatic test_reset();
    logic ok_sd, ok_bc, ok_lr, ok_fs;
    int b;
    rst = 1'b1; in_valid = 1'b0; in_left = '0; in_right = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bclk, lrck, sdata, frame_start, underrun, in_ready} !== 6'b000001) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 000001", {bclk, lrck, sdata, frame_start, underrun, in_ready});
    end
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      checks++;
      if ({frame_start, underrun} !== ((n == 3) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL first_frame_cycle%0d got fs/un %b", n, {frame_start, underrun});
      end
    end
    ok_sd = 1'b1; ok_bc = 1'b1; ok_lr = 1'b1; ok_fs = 1'b1;
    for (int n = 4; n < 260; n++) begin
      @(negedge clk);
      b = ((n - 4) / 4) % 64;
      if (sdata !== 1'b0) ok_sd = 1'b0;
      if (bclk !== ((n % 4) >= 2)) ok_bc = 1'b0;
      if (lrck !== (((b + 1) % 64) >= 32)) ok_lr = 1'b0;
      if ({frame_start, underrun} !== ((n == 259) ? 2'b11 : 2'b00)) ok_fs = 1'b0;
    end
    checks++; if (!ok_sd) begin errors++; $display("FAIL silent_frame sdata got nonzero exp 0"); end
    checks++; if (!ok_bc) begin errors++; $display("FAIL bclk_pattern got wrong phase exp high on cnt 2,3"); end
    checks++; if (!ok_lr) begin errors++; $display("FAIL lrck_pattern got wrong exp ((b+1)%%64)>=32"); end
    checks++; if (!ok_fs) begin errors++; $display("FAIL frame_period got wrong fs/underrun exp pulse at 259"); end
  endtask

  task automatic test_single();
    logic [63:0] sd, lr, bc, e;
    logic un, found;
    do_reset();
    in_valid = 1'b1; in_left = 24'h800001; in_right = 24'h7FFFFF;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_ready_pre got %b exp 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL single_ready_full got %b exp 0", in_ready); end
    capture_frame(sd, lr, bc, un, found);
    e = exp_frame(24'h800001, 24'h7FFFFF);
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL single_timeout got no frame_start"); end
    checks++; if (un !== 1'b0) begin errors++; $display("FAIL single_underrun got %b exp 0", un); end
    checks++; if (sd !== e) begin errors++; $display("FAIL single_sdata got %h exp %h", sd, e); end
    checks++; if (lr !== exp_lr()) begin errors++; $display("FAIL single_lrck got %h exp %h", lr, exp_lr()); end
    checks++; if (bc !== '1) begin errors++; $display("FAIL single_bclk_high got %h exp all ones", bc); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_ready_drained got %b exp 1", in_ready); end
    capture_frame(sd, lr, bc, un, found);
    checks++; if ({found, un} !== 2'b11) begin errors++; $display("FAIL single_next_underrun got %b exp 11", {found, un}); end
    checks++; if (sd !== '0) begin errors++; $display("FAIL single_next_silent got %h exp 0", sd); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] sl [4];
    logic [23:0] sr [4];
    int acc_cyc [4];
    logic [63:0] sd [4];
    logic [63:0] lr, bc;
    logic un [4];
    logic found [4];
    sl = '{24'h123456, 24'hFEDCBA, 24'h000001, 24'hC0FFEE};
    sr = '{24'hABCDEF, 24'h0F0F0F, 24'h800000, 24'h5A5A5A};
    do_reset();
    fork
      begin
        int cyc, w;
        logic acc;
        cyc = 0;
        for (int i = 0; i < 4; i++) begin
          in_valid = 1'b1; in_left = sl[i]; in_right = sr[i];
          acc = 1'b0; w = 0;
          while (!acc && w < 600) begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1; cyc++; w++;
          end
          acc_cyc[i] = acc ? cyc : -1;
        end
        in_valid = 1'b0;
      end
      begin
        for (int f = 0; f < 4; f++) capture_frame(sd[f], lr, bc, un[f], found[f]);
      end
    join
    checks++; if (acc_cyc[0] !== 1) begin errors++; $display("FAIL stream_first_accept got %0d exp 1", acc_cyc[0]); end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (acc_cyc[i+1] - acc_cyc[i] !== 256) begin
        errors++;
        $display("FAIL stream_accept_spacing%0d got %0d exp 256", i, acc_cyc[i+1] - acc_cyc[i]);
      end
    end
    for (int f = 0; f < 4; f++) begin
      checks++;
      if ({found[f], un[f]} !== 2'b10) begin
        errors++; $display("FAIL stream_frame%0d_flags got %b exp 10", f, {found[f], un[f]});
      end
      checks++;
      if (sd[f] !== exp_frame(sl[f], sr[f])) begin
        errors++; $display("FAIL stream_frame%0d_data got %h exp %h", f, sd[f], exp_frame(sl[f], sr[f]));
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [63:0] sd, lr, bc;
    logic un, found, silent;
    do_reset();
    repeat (3) @(posedge clk);
    #1;  // cycle 3: the first frame-start tick
    in_valid = 1'b1; in_left = 24'h13579B; in_right = 24'hECA864;
    @(negedge clk);
    checks++;
    if ({frame_start, underrun, in_ready} !== 3'b111) begin
      errors++; $display("FAIL simul_tick got fs/un/rdy %b exp 111", {frame_start, underrun, in_ready});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL simul_held got %b exp 0", in_ready); end
    silent = 1'b1;
    for (int n = 4; n < 259; n++) begin
      @(negedge clk);
      if (sdata !== 1'b0) silent = 1'b0;
    end
    checks++; if (!silent) begin errors++; $display("FAIL simul_current_silent got nonzero exp 0"); end
    capture_frame(sd, lr, bc, un, found);
    checks++; if ({found, un} !== 2'b10) begin errors++; $display("FAIL simul_next_flags got %b exp 10", {found, un}); end
    checks++;
    if (sd !== exp_frame(24'h13579B, 24'hECA864)) begin
      errors++; $display("FAIL simul_next_data got %h exp %h", sd, exp_frame(24'h13579B, 24'hECA864));
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] sd, lr, bc;
    logic un, found;
    do_reset();
    in_valid = 1'b1; in_left = 24'hFFFFFF; in_right = 24'hFFFFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;  // cycle 4, holding register drained
    in_valid = 1'b1; in_left = 24'hDEAD01; in_right = 24'hBEEF02;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_held got %b exp 0", in_ready); end
    repeat (159) @(posedge clk);
    #1;  // cycle 164: b = 40, right slot
    checks++; if (lrck !== 1'b1) begin errors++; $display("FAIL mid_pre_lrck got %b exp 1", lrck); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bclk, lrck, sdata, frame_start, underrun, in_ready} !== 6'b000001) begin
      errors++; $display("FAIL mid_reset_outputs got %b exp 000001", {bclk, lrck, sdata, frame_start, underrun, in_ready});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int f = 0; f < 2; f++) begin
      capture_frame(sd, lr, bc, un, found);
      checks++;
      if ({found, un} !== 2'b11 || sd !== '0) begin
        errors++; $display("FAIL mid_discard%0d got flags %b data %h exp 11 / 0", f, {found, un}, sd);
      end
    end
  endtask

  task automatic test_sweep();
    logic [47:0] sd, lr, e, el;
    logic bc_lo, bc_hi, fs_quiet;
    rst2 = 1'b1; v2 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst2 = 1'b0;
    v2 = 1'b1; l2 = 24'hA5A5A5; r2 = 24'h5A5A5A;
    checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL sweep_ready got %b exp 1", rdy2); end
    @(posedge clk); #1;
    v2 = 1'b0;
    @(negedge clk);  // cycle 1: first tick
    checks++;
    if ({fs2, un2} !== 2'b10) begin errors++; $display("FAIL sweep_first_fs got %b exp 10", {fs2, un2}); end
    bc_lo = 1'b1; bc_hi = 1'b1; fs_quiet = 1'b1; sd = '0; lr = '0;
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      if (bclk2 !== 1'b0) bc_lo = 1'b0;
      if (fs2 !== 1'b0) fs_quiet = 1'b0;
      @(negedge clk);
      if (bclk2 !== 1'b1) bc_hi = 1'b0;
      if (k < 47 && fs2 !== 1'b0) fs_quiet = 1'b0;
      sd[k] = sdata2; lr[k] = lrck2;
    end
    for (int k = 0; k < 48; k++) begin
      e[k]  = (k < 24) ? l2[23-k] : r2[47-k];
      el[k] = (((k + 1) % 48) >= 24);
    end
    checks++; if (!(bc_lo && bc_hi)) begin errors++; $display("FAIL sweep_bclk_toggle got %b%b exp 11", bc_lo, bc_hi); end
    checks++; if (sd !== e) begin errors++; $display("FAIL sweep_sdata got %h exp %h", sd, e); end
    checks++; if (lr !== el) begin errors++; $display("FAIL sweep_lrck got %h exp %h", lr, el); end
    checks++; if (!fs_quiet) begin errors++; $display("FAIL sweep_no_early_fs got extra pulse exp none"); end
    checks++;
    if ({fs2, un2} !== 2'b11) begin errors++; $display("FAIL sweep_frame96 got %b exp 11", {fs2, un2}); end
  endtask

  initial begin
    rst2 = 1'b1; v2 = 1'b0; l2 = '0; r2 = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
